// File: rtl/uart_rx_frame_parser_pkg.sv
// Shared constants and state encoding for the point-stream UART framer/parser pair.
// The matching transmit-side framer uses the same byte values.
package uart_rx_frame_parser_pkg;

    localparam logic [7:0] SOF0 = 8'h53;
    localparam logic [7:0] SOF1 = 8'h54;
    localparam logic [7:0] EOF0 = 8'h45;
    localparam logic [7:0] EOF1 = 8'h4E;
    localparam logic [7:0] EOF2 = 8'h44;

    localparam int FRAME_LEN   = 9;
    localparam int PAYLOAD_LEN = 4;
    localparam int IDX_W       = 3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_GOT_S = 3'd1,
        ST_DATA  = 3'd2,
        ST_GOT_E = 3'd3,
        ST_GOT_N = 3'd4
    } parse_state_t;

    // A bad trailer byte that is itself a start byte is treated as the next frame's header.
    function automatic parse_state_t abort_state(input logic [7:0] b);
        return (b == SOF0) ? ST_GOT_S : ST_IDLE;
    endfunction

endpackage

// File: rtl/uart_rx_frame_parser_idle_timer.sv
// Inter-byte idle timer: reloads on clr, counts down while en, and flags the
// cycle in which the count would reach zero. LOAD = 0 disables expiry.
module uart_rx_idle_timer #(
    parameter int unsigned LOAD = 20000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int unsigned W = (LOAD < 2) ? 1 : $clog2(LOAD + 1);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= W'(LOAD);
        end else if (en && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    // Terminal count: the state change lands exactly LOAD cycles after the last reload.
    assign expire = en && !clr && (count == W'(1));

endmodule

// File: rtl/uart_rx_frame_parser.sv
// Parses "ST" + 4 payload bytes + "END" frames from a UART RX byte stream and
// publishes the X/Y point carried in each valid frame.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | hunting for 'S'
// GOT_S    | 'S' seen, expecting 'T' (repeated 'S' stays here)
// DATA     | collecting payload; idx == 4 means payload full, expecting 'E'
// GOT_E    | 'E' seen, expecting 'N'
// GOT_N    | 'N' seen, expecting 'D'
module uart_rx_frame_parser
    import uart_rx_frame_parser_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 20000,
    parameter int unsigned CNT_W          = 16
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [7:0]       RX_BYTE,
    input  logic             RX_DV,
    output logic [15:0]      POINTS_H,
    output logic [15:0]      POINTS_V,
    output logic             FRAME_VALID,
    output logic             FRAME_ERR,
    output logic [CNT_W-1:0] FRAME_CNT,
    output logic [7:0]       ERR_CNT,
    output logic             BUSY
);

    parse_state_t     state, state_nxt;
    logic [IDX_W-1:0] idx, idx_nxt;
    logic [31:0]      data_sr, data_sr_nxt;
    logic             valid_nxt;
    logic             err_nxt;
    logic             tmr_expire;

    uart_rx_idle_timer #(
        .LOAD (TIMEOUT_CYCLES)
    ) u_idle_timer (
        .clk    (CLK),
        .rst_n  (RST_N),
        .clr    (RX_DV),
        .en     (state != ST_IDLE),
        .expire (tmr_expire)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state   <= ST_IDLE;
            idx     <= '0;
            data_sr <= '0;
        end else begin
            state   <= state_nxt;
            idx     <= idx_nxt;
            data_sr <= data_sr_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        idx_nxt     = idx;
        data_sr_nxt = data_sr;
        valid_nxt   = 1'b0;
        err_nxt     = 1'b0;
        if (RX_DV) begin
            unique case (state)
                ST_IDLE: begin
                    if (RX_BYTE == SOF0) state_nxt = ST_GOT_S;
                end
                ST_GOT_S: begin
                    if (RX_BYTE == SOF1) begin
                        state_nxt = ST_DATA;
                        idx_nxt   = '0;
                    end else if (RX_BYTE != SOF0) begin
                        state_nxt = ST_IDLE;
                    end
                end
                ST_DATA: begin
                    if (idx != IDX_W'(PAYLOAD_LEN)) begin
                        data_sr_nxt = {data_sr[23:0], RX_BYTE};
                        idx_nxt     = idx + 1'b1;
                    end else if (RX_BYTE == EOF0) begin
                        state_nxt = ST_GOT_E;
                    end else begin
                        err_nxt   = 1'b1;
                        state_nxt = abort_state(RX_BYTE);
                    end
                end
                ST_GOT_E: begin
                    if (RX_BYTE == EOF1) begin
                        state_nxt = ST_GOT_N;
                    end else begin
                        err_nxt   = 1'b1;
                        state_nxt = abort_state(RX_BYTE);
                    end
                end
                ST_GOT_N: begin
                    if (RX_BYTE == EOF2) begin
                        valid_nxt = 1'b1;
                        state_nxt = ST_IDLE;
                    end else begin
                        err_nxt   = 1'b1;
                        state_nxt = abort_state(RX_BYTE);
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end else if (tmr_expire) begin
            // An unconfirmed header times out silently; a started frame is an error.
            state_nxt = ST_IDLE;
            err_nxt   = (state != ST_GOT_S) && (state != ST_IDLE);
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            POINTS_H    <= '0;
            POINTS_V    <= '0;
            FRAME_VALID <= 1'b0;
            FRAME_ERR   <= 1'b0;
            FRAME_CNT   <= '0;
            ERR_CNT     <= '0;
        end else begin
            FRAME_VALID <= valid_nxt;
            FRAME_ERR   <= err_nxt;
            if (valid_nxt) begin
                POINTS_H  <= data_sr[31:16];
                POINTS_V  <= data_sr[15:0];
                FRAME_CNT <= FRAME_CNT + 1'b1;
            end
            if (err_nxt && (ERR_CNT != 8'hFF)) begin
                ERR_CNT <= ERR_CNT + 1'b1;
            end
        end
    end

    assign BUSY = (state != ST_IDLE);

endmodule
